// File: rtl/signed_addsub_pipe_if.sv
// Operand/result handshake bundle for signed_addsub_pipe.
// master drives operands and downstream ready; slave is the pipeline itself.
interface signed_addsub_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic [WIDTH-1:0] result_sat;
    logic             ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             cnt_clr;

    modport master (
        output in_valid, a, b, op, out_ready, cnt_clr,
        input  in_ready, out_valid, result, result_sat, ovf, ovf_count
    );

    modport slave (
        input  in_valid, a, b, op, out_ready, cnt_clr,
        output in_ready, out_valid, result, result_sat, ovf, ovf_count
    );
endinterface

// File: rtl/signed_addsub_pipe.sv
// Signed add/subtract with full-precision and saturated results plus overflow event count.
// Latency 2 cycles from input transfer to out_valid; one transfer per cycle.
// Backpressure: stage 2 holds under !out_ready, in_ready drops only when both stages are stuck.
module signed_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    signed_addsub_pipe_if.slave  io
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
    } opnd_t;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid;
    opnd_t            s1_dat;
    logic             s1_advance;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] sum_sat;

    assign s1_advance  = s1_valid && (!io.out_valid || io.out_ready);
    assign io.in_ready = !s1_valid || s1_advance;
    assign in_fire     = io.in_valid && io.in_ready;
    assign out_fire    = io.out_valid && io.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_dat.a  <= io.a;
            s1_dat.b  <= io.b;
            s1_dat.op <= io.op;
        end
    end

    // One extra bit keeps the sum exact; overflow shows as the top two bits disagreeing.
    always_comb begin
        a_ext   = {s1_dat.a[WIDTH-1], s1_dat.a};
        b_ext   = {s1_dat.b[WIDTH-1], s1_dat.b};
        sum     = s1_dat.op ? (a_ext + b_ext) : (a_ext - b_ext);
        sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        sum_sat = sum[WIDTH-1:0];
        if (sum_ovf) begin
            sum_sat = sum[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid  <= 1'b0;
            io.result     <= '0;
            io.result_sat <= '0;
            io.ovf        <= 1'b0;
        end else if (s1_advance) begin
            io.out_valid  <= 1'b1;
            io.result     <= sum;
            io.result_sat <= sum_sat;
            io.ovf        <= sum_ovf;
        end else if (io.out_ready) begin
            io.out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.ovf_count <= '0;
        end else if (io.cnt_clr) begin
            io.ovf_count <= '0;
        end else if (out_fire && io.ovf && (io.ovf_count != '1)) begin
            io.ovf_count <= io.ovf_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Bench for signed_addsub_pipe: directed WIDTH=4/CNT_W=2 instance plus randomized WIDTH=8 instance.
module tb_signed_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signed_addsub_pipe_if #(.WIDTH(4), .CNT_W(2)) u4 ();
    signed_addsub_pipe_if #(.WIDTH(8), .CNT_W(16)) u8 ();

    signed_addsub_pipe #(.WIDTH(4), .CNT_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .io(u4));
    signed_addsub_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (.clk(clk), .rst_n(rst_n), .io(u8));

    typedef struct {
        int res;
        int sat;
        bit ovf;
        int cyc;
    } exp_t;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q4[$];
    exp_t q8[$];
    int   cyc4 = 0;
    int   cnt4 = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input bit op, input int cyc);
        exp_t e;
        int mx;
        int mn;
        mx    = (1 << (w - 1)) - 1;
        mn    = -(1 << (w - 1));
        e.res = op ? a + b : a - b;
        e.ovf = (e.res > mx) || (e.res < mn);
        e.sat = (e.res > mx) ? mx : ((e.res < mn) ? mn : e.res);
        e.cyc = cyc;
        return e;
    endfunction

    function automatic int sx(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    // One cycle on the WIDTH=4 unit; every output is compared with the oldest item in flight.
    task automatic step4(input bit v, input int a, input int b, input bit op,
                         input bit ordy, input bit clr, output bit acc);
        bit fire_out;
        @(negedge clk);
        check("cnt4", u4.ovf_count, cnt4);
        u4.in_valid  = v;
        u4.a         = a[3:0];
        u4.b         = b[3:0];
        u4.op        = op;
        u4.out_ready = ordy;
        u4.cnt_clr   = clr;
        #1;
        check("ovld4", u4.out_valid, (q4.size() > 0) ? (cyc4 - q4[0].cyc >= 2) : 0);
        check("irdy4", u4.in_ready, !(q4.size() >= 2 && !ordy));
        if (u4.out_valid && q4.size() > 0) begin
            check("res4", $signed(u4.result), q4[0].res);
            check("sat4", $signed(u4.result_sat), q4[0].sat);
            check("ovf4", u4.ovf, q4[0].ovf);
        end
        fire_out = u4.out_valid && ordy && (q4.size() > 0);
        acc      = v && u4.in_ready;
        if (clr) cnt4 = 0;
        else if (fire_out && q4[0].ovf && cnt4 < 3) cnt4++;
        if (fire_out) void'(q4.pop_front());
        if (acc) q4.push_back(model(4, a, b, op, cyc4));
        cyc4++;
    endtask

    int  ta[5] = '{3, -4, 7, -5, 6};
    int  tb[5] = '{2, 1, -2, -3, 7};
    int  sa[3] = '{-8, 7, 0};
    int  sbv[3] = '{-8, 1, -8};
    bit  sop[3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        bit acc;
        int k;
        int n_in, n_out, n_ovf, cyc8;
        bit v, ordy, rop;
        int ra, rb;

        u4.in_valid = 0; u4.a = '0; u4.b = '0; u4.op = 0; u4.out_ready = 0; u4.cnt_clr = 0;
        u8.in_valid = 0; u8.a = '0; u8.b = '0; u8.op = 0; u8.out_ready = 0; u8.cnt_clr = 0;

        #3;
        check("rst_ovld4", u4.out_valid, 0);
        check("rst_res4", u4.result, 0);
        check("rst_sat4", u4.result_sat, 0);
        check("rst_ovf4", u4.ovf, 0);
        check("rst_cnt4", u4.ovf_count, 0);
        check("rst_ovld8", u8.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_irdy4", u4.in_ready, 1);
        check("rst_irdy8", u8.in_ready, 1);

        // Back-to-back subtraction, no backpressure.
        for (int i = 0; i < 5; i++) begin
            step4(1, ta[i], tb[i], 0, 1, 0, acc);
            check("b2b_acc", acc, 1);
        end
        for (int i = 0; i < 3; i++) step4(0, 0, 0, 0, 1, 0, acc);

        // Extreme operands: min+min, max+1, 0-min.
        for (int i = 0; i < 3; i++) step4(1, sa[i], sbv[i], sop[i], 1, 0, acc);
        for (int i = 0; i < 3; i++) step4(0, 0, 0, 0, 1, 0, acc);

        // Backpressure: out_ready low for 4 cycles while streaming 5 transfers.
        k = 0;
        for (int s = 0; s < 20; s++) begin
            step4(k < 5, ta[k % 5], tb[k % 5], 1, !(s >= 2 && s < 6), 0, acc);
            if (acc) k++;
        end
        check("bp_sent", k, 5);
        check("bp_drained", q4.size(), 0);

        // Counter saturation at CNT_W=2, then clear on the same cycle as an overflow transfer.
        step4(0, 0, 0, 0, 1, 1, acc);
        for (int i = 0; i < 5; i++) step4(1, 7, 1, 1, 1, 0, acc);
        for (int i = 0; i < 3; i++) step4(0, 0, 0, 0, 1, 0, acc);
        check("cnt_sat", u4.ovf_count, 3);
        step4(1, -8, 1, 0, 1, 0, acc);
        step4(0, 0, 0, 0, 1, 0, acc);
        step4(0, 0, 0, 0, 1, 1, acc);
        step4(0, 0, 0, 0, 1, 0, acc);
        check("cnt_clr", u4.ovf_count, 0);

        // Asynchronous reset with both stages full.
        step4(1, 7, 7, 1, 0, 0, acc);
        step4(1, -3, 2, 0, 0, 0, acc);
        step4(1, 1, 1, 1, 0, 0, acc);
        step4(1, 5, -8, 0, 1, 1, acc);
        step4(1, 6, 6, 1, 0, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ovld", u4.out_valid, 0);
        check("arst_res", u4.result, 0);
        check("arst_sat", u4.result_sat, 0);
        check("arst_ovf", u4.ovf, 0);
        check("arst_cnt", u4.ovf_count, 0);
        q4.delete();
        cnt4 = 0;
        u4.in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_irdy", u4.in_ready, 1);
        step4(1, 5, -3, 1, 1, 0, acc);
        for (int i = 0; i < 3; i++) step4(0, 0, 0, 0, 1, 0, acc);

        // Randomized traffic on the WIDTH=8 unit.
        n_in = 0; n_out = 0; n_ovf = 0; cyc8 = 0;
        for (int s = 0; s < 60000 && n_out < 10000; s++) begin
            @(negedge clk);
            v    = (n_in < 10000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ra   = $urandom_range(0, 255);
            rb   = $urandom_range(0, 255);
            rop  = $urandom_range(0, 1) == 1;
            u8.in_valid  = v;
            u8.a         = ra[7:0];
            u8.b         = rb[7:0];
            u8.op        = rop;
            u8.out_ready = ordy;
            #1;
            check("ovld8", u8.out_valid, (q8.size() > 0) ? (cyc8 - q8[0].cyc >= 2) : 0);
            check("irdy8", u8.in_ready, !(q8.size() >= 2 && !ordy));
            if (u8.out_valid && q8.size() > 0) begin
                check("res8", $signed(u8.result), q8[0].res);
                check("sat8", $signed(u8.result_sat), q8[0].sat);
                check("ovf8", u8.ovf, q8[0].ovf);
                if (ordy) begin
                    if (q8[0].ovf) n_ovf++;
                    void'(q8.pop_front());
                    n_out++;
                end
            end
            if (v && u8.in_ready) begin
                q8.push_back(model(8, sx(ra, 8), sx(rb, 8), rop, cyc8));
                n_in++;
            end
            cyc8++;
        end
        check("rnd_outputs", n_out, 10000);
        @(negedge clk);
        u8.in_valid  = 0;
        u8.out_ready = 0;
        #1;
        check("rnd_cnt", u8.ovf_count, n_ovf);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/signed_addsub_pipe.md
Name: signed_addsub_pipe

Overview:
- Parametrised, two-stage pipelined signed add/subtract unit; successor to the fixed 4-bit combinational signed subtractor.
- Per-transaction operation select: add or subtract.
- Produces a full-precision (WIDTH+1) result and a saturated WIDTH-bit result with an overflow flag.
- Valid/ready handshake on both sides with full backpressure, plus a saturating overflow event counter. Sits between operand sources and downstream DSP/ALU datapaths.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); legal range 2..32.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  unit can accept operands this cycle.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- op  input  1  0 = A-B, 1 = A+B; sampled with operands.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH+1  signed full-precision result, never overflows.
- result_sat  output  WIDTH  signed result clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- ovf  output  1  full result outside WIDTH-bit range (result_sat clamped).
- ovf_count  output  CNT_W  number of overflowed results delivered; saturates at all-ones.
- cnt_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 registers a, b and op on input transfer. Stage 2 registers the computed result, result_sat and ovf.
- Latency is 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Stage 2 loads when stage 1 is valid and (stage 2 is empty or out_ready).
- Stage 1 loads when stage 1 is empty or stage 1 is advancing to stage 2.
- in_ready = !s1_valid || s1_advance. It must not depend combinationally on in_valid.
- result_sat and ovf are registered. out_valid is the stage-2 valid flag.
- Stage 2 holds result, result_sat and ovf stable while out_valid && !out_ready.
- Arithmetic:
  - Sign-extend both operands to WIDTH+1, then result = a ± b.
  - ovf = (result > 2^(WIDTH-1)-1) or (result < -2^(WIDTH-1)).
  - On positive overflow, result_sat = max positive. On negative overflow, result_sat = min negative. Otherwise result_sat = result[WIDTH-1:0].
- Subtracting the minimum negative value (e.g. 0 - (-8) at WIDTH=4) gives full result +8, ovf=1, result_sat=+7.
- ovf_count:
  - Increments by 1 on each output transfer with ovf=1. Holds at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment; the count becomes 0.
- Reset (asynchronous, any time, including mid-stream):
  - Both valid flags clear and in-flight data is discarded.
  - Outputs: out_valid=0, result=0, result_sat=0, ovf=0, ovf_count=0.
  - in_ready=1 once reset is deasserted.
- Data registers other than the outputs need no reset. Outputs above must read 0 during reset.
- Simultaneous input and output transfer with both stages full: the pipeline shifts with no bubble and no data loss.
- Values on a/b/op while in_valid=0 are ignored.

Test Plan:
- WIDTH=4, op=0, back-to-back, out_ready=1. Pairs (3,2), (-4,1), (7,-2), (-5,-3), (6,7) give result 1, -5, 9, -2, -1; result_sat 1, -5, 7, -2, -1; ovf only on the third. Each output appears 2 cycles after input, with no bubbles.
- WIDTH=4, op=1: (-8,-8) gives result=-16, result_sat=-8, ovf=1. (7,1) gives result=8, result_sat=7, ovf=1. (0,-8) with op=0 gives result=8, result_sat=7, ovf=1.
- Backpressure: stream 5 transfers, hold out_ready=0 for 4 cycles mid-stream. in_ready drops after both stages fill, the held output stays stable, and all 5 results arrive in order with no loss or duplication.
- Counter: CNT_W=2, 5 overflowing transfers give ovf_count 1, 2, 3, 3, 3. cnt_clr in the same cycle as an overflow transfer gives 0.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) with both stages full. out_valid=0, result=0 and ovf_count=0 immediately. After release, in_ready=1 and the next transfer returns a correct result after 2 cycles.
- Random: 10k transactions at WIDTH=8 with random valid/ready. Results match the reference model, and ovf_count equals the number of overflow outputs.
